// File: rtl/max_pool2d_pkg.sv
// max_pool2d_pkg: width helper and default feature-map constants shared with the convolution stage
package max_pool2d_pkg;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int FMAP_SIZE = 28;
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/max_pool2d_max2.sv
// max2: combinational unsigned maximum; a tie returns a
module max2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  assign y = (b > a) ? b : a;
endmodule

// File: rtl/max_pool2d.sv
// max_pool2d: streaming 2x2 stride-2 max pooling over a raster-order feature map.
// Even rows park horizontal pair maxima in a half-width line buffer; odd rows merge them.
module max_pool2d
  import max_pool2d_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IN_SIZE = FMAP_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] pool_out,
  output logic                  pool_valid,
  output logic                  done
);
  localparam int CW = clogb2(IN_SIZE);
  localparam int AW = clogb2(IN_SIZE / 2);
  localparam int DEPTH = IN_SIZE / 2;
  localparam logic [CW-1:0] WIN_LAST = CW'(2 * DEPTH - 1);
  localparam logic [CW-1:0] MAP_LAST = CW'(IN_SIZE - 1);
  logic [CW-1:0] col, row;
  logic [DATA_WIDTH-1:0] h_first, h_max, v_max, pool_q, rd;
  logic [DATA_WIDTH-1:0] line_buf [DEPTH];
  logic [AW-1:0] addr;
  logic accept, in_win, wr, fire, valid_q, done_q;
  assign accept = ena & din_valid & ~clear;
  // odd trailing column/row falls outside the window and is dropped
  assign in_win = (col <= WIN_LAST) && (row <= WIN_LAST);
  assign addr = AW'(col >> 1);
  assign wr = accept & in_win & col[0] & ~row[0];
  assign fire = accept & in_win & col[0] & row[0];
  assign rd = line_buf[addr];
  max2 #(.DATA_WIDTH(DATA_WIDTH)) u_h (.a(h_first), .b(din), .y(h_max));
  max2 #(.DATA_WIDTH(DATA_WIDTH)) u_v (.a(rd), .b(h_max), .y(v_max));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      h_first <= '0;
      pool_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
      h_first <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      valid_q <= fire;
      done_q <= fire && (col == WIN_LAST) && (row == WIN_LAST);
      if (fire) pool_q <= v_max;
      if (accept) begin
        col <= (col == MAP_LAST) ? '0 : col + 1'b1;
        if (col == MAP_LAST) row <= (row == MAP_LAST) ? '0 : row + 1'b1;
        if (!col[0]) h_first <= din;
      end
    end
  end
  always_ff @(posedge clk) if (wr) line_buf[addr] <= h_max;
  assign pool_out = valid_q ? pool_q : '0;
  assign pool_valid = valid_q;
  assign done = done_q;
endmodule

// File: doc/max_pool2d.md
MAX_POOL2D -- requirements
Module: max_pool2d

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width in bits.
REQ-002 SHALL have parameter IN_SIZE, default 28: input map side length in samples; legal range 2..256.
REQ-003 SHALL have a fixed pooling window of 2x2 with stride 2; it SHALL NOT be a parameter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 ena  input  1  enable; when low, all state holds and din_valid is ignored.
REQ-007 clear  input  1  synchronous restart of the map; takes priority over ena.
REQ-008 din  input  DATA_WIDTH  convolution result, raster order, unsigned.
REQ-009 din_valid  input  1  din carries the next raster sample; no backpressure exists.
REQ-010 pool_out  output  DATA_WIDTH  pooled maximum; forced to 0 whenever pool_valid is low.
REQ-011 pool_valid  output  1  pool_out is valid this cycle.
REQ-012 done  output  1  one-cycle pulse, coincident with the last pool_valid of a map.

Function
REQ-013 SHALL count accepted samples (ena & din_valid) with column counter col (0..IN_SIZE-1) and row counter row (0..IN_SIZE-1).
REQ-014 When col wraps from IN_SIZE-1 to 0, row SHALL increment; when row also wraps, both SHALL return to 0, ready for the next map.
REQ-015 On an even col, the block SHALL register din as h_first.
REQ-016 On an odd col, the block SHALL form h_max = max(h_first, din) using an unsigned compare; on a tie it SHALL take h_first.
REQ-017 On an even row with an odd col, the block SHALL write h_max into line buffer entry col>>1; the depth of the buffer is IN_SIZE/2 (floor).
REQ-018 On an odd row with an odd col, the block SHALL register pool_out = max(buf[col>>1], h_max) and assert pool_valid on the next cycle (latency 1 cycle from the final sample).
REQ-019 For odd IN_SIZE, the last column and the last row SHALL be discarded (floor behaviour); they produce no output and do not write the buffer.
REQ-020 Output count per map SHALL be (IN_SIZE/2)^2, and outputs SHALL appear in raster order.
REQ-021 done SHALL assert with the output taken from row 2*(IN_SIZE/2)-1, col 2*(IN_SIZE/2)-1.
REQ-022 If ena is low in the cycle in which pool_valid would assert, the output SHALL still be issued (the register was loaded earlier); ena only gates sample acceptance.
REQ-023 Gaps in din_valid of any length SHALL NOT alter results.
REQ-024 clear SHALL zero col, row, h_first, pool_valid and done in the next cycle; buffer contents need not be cleared.
REQ-025 When clear and din_valid are high together, the sample SHALL be discarded.

Reset
REQ-026 While rst_n is low at a clock edge, col, row, h_first, pool_out, pool_valid and done SHALL go to 0.
REQ-027 Line buffer contents SHALL NOT be reset; no output may depend on a buffer entry before that entry is written in the current map.
REQ-028 Reset asserted mid-map SHALL abandon the map; the first sample accepted afterwards SHALL be treated as row 0, col 0.

Structure
REQ-029 The shared package SHALL hold the clogb2 width function and the default DATA_WIDTH and feature-map size constants, so they are shared with the convolution stage.
REQ-030 The counter widths SHALL be clogb2(IN_SIZE); the buffer address width SHALL be clogb2(IN_SIZE/2).
REQ-031 The block SHALL contain one sub-module, max2: a combinational unsigned two-input maximum, instantiated twice (horizontal and vertical stage).
REQ-032 The line buffer SHALL be a register array inferable as distributed RAM, with one write port and one read port.

Verification (IN_SIZE=4 unless stated)
REQ-033 Stream 0..15 with no gaps -> pool_valid asserts 4 times with values 5, 7, 13, 15; done asserts with 15.
REQ-034 Same stream with random din_valid/ena gaps -> identical values and order; done fires exactly once.
REQ-035 Ties and maximum values: all samples 16'hFFFF, then all 0 in the next map -> outputs FFFF x4, then 0 x4; counters wrap correctly between maps.
REQ-036 IN_SIZE=5, stream 0..24 -> outputs 6, 8, 16, 18; samples from col 4 and row 4 produce nothing.
REQ-037 Pulse clear after sample 9 of a map, then stream 0..15 -> only the post-clear outputs 5, 7, 13, 15.
REQ-038 Drop rst_n for one cycle at sample 6, then stream 0..15 -> outputs 5, 7, 13, 15; pool_out is 0 whenever pool_valid is low.
